// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: unsigned DIVIDEND_W-bit dividend divided by a
// DIVISOR_W-bit divisor, one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero short-circuits to an all-ones quotient with div_by_zero set.
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [DIVIDEND_W-1:0]   d_reg, d_next;       // dividend bits still to bring down
    logic [DIVISOR_W-1:0]    v_reg, v_next;       // captured divisor
    logic [DIVISOR_W-1:0]    r_reg, r_next;       // partial remainder, always < divisor
    logic [DIVIDEND_W-1:0]   q_reg, q_next;       // quotient being assembled
    logic [CNT_W-1:0]        cnt_reg, cnt_next;   // quotient bits left to produce
    logic [DIVIDEND_W-1:0]   quot_reg, quot_next;
    logic [DIVISOR_W-1:0]    rem_reg, rem_next;
    logic                    dbz_reg, dbz_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;

    // Trial value is one bit wider than the divisor so the compare and the
    // subtract never overflow; the stored remainder fits DIVISOR_W bits
    // because it is always smaller than the divisor.
    logic [DIVISOR_W:0]      trial;
    logic                    trial_ge;

    assign trial    = {r_reg, d_reg[DIVIDEND_W-1]};
    assign trial_ge = (trial >= {1'b0, v_reg});

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quot_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dbz_reg;

    // Next-state and datapath update: accept in IDLE/DONE, one restoring step per RUN cycle.
    always_comb begin
        state_next = state_reg;
        d_next     = d_reg;
        v_next     = v_reg;
        r_next     = r_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        dbz_next   = dbz_reg;

        case (state_reg)
            IDLE, DONE: begin
                // DONE lasts one cycle but accepts a new request just like IDLE.
                state_next = IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        d_next     = dividend;
                        v_next     = divisor;
                        r_next     = '0;
                        q_next     = '0;
                        cnt_next   = CNT_W'(DIVIDEND_W);
                        state_next = RUN;
                    end else begin
                        quot_next  = '1;
                        rem_next   = '0;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                d_next   = {d_reg[DIVIDEND_W-2:0], 1'b0};
                r_next   = trial_ge ? DIVISOR_W'(trial - {1'b0, v_reg})
                                    : trial[DIVISOR_W-1:0];
                q_next   = {q_reg[DIVIDEND_W-2:0], trial_ge};
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    quot_next  = {q_reg[DIVIDEND_W-2:0], trial_ge};
                    rem_next   = r_next;
                    dbz_next   = 1'b0;
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            d_reg     <= '0;
            v_reg     <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dbz_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            d_reg     <= d_next;
            v_reg     <= v_next;
            r_reg     <= r_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            dbz_reg   <= dbz_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider (default 8/4 widths): directed table,
// hand-written corner sequences, and a shuffled exhaustive sweep checked
// against a plain-arithmetic reference model.
module tb_seq_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    seq_restoring_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Last result the outputs are expected to hold between done pulses.
    logic [DW-1:0] hold_q = '0;
    logic [VW-1:0] hold_r = '0;
    logic          hold_z = 1'b0;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
    } vec_t;

    vec_t vecs[5];
    int   perm[4096];

    task automatic check(input string name, input bit ok, input string got, input string exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %s, expected %s", name, got, exp);
    endtask

    // Reference model: plain integer division, all-ones quotient on zero divisor.
    task automatic ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q = '1;
            r = '0;
            z = 1'b1;
        end else begin
            q = DW'(ai / bi);
            r = VW'(ai % bi);
            z = 1'b0;
        end
    endtask

    // Issue one request at the current negedge, wait for done, check everything.
    // Accepting edge plus DW run edges for a real division, one edge for /0.
    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ez);
        int edges;
        int exp_edges;
        bit busy_seen, busy_all, held_ok;
        edges     = 0;
        busy_seen = 1'b0;
        busy_all  = 1'b1;
        held_ok   = 1'b1;
        exp_edges = (b != '0) ? DW + 1 : 1;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        do begin
            @(negedge clk);
            edges++;
            start    = 1'b0;
            dividend = DW'($urandom);
            divisor  = VW'($urandom);
            if (!done) begin
                if (busy) busy_seen = 1'b1;
                else      busy_all  = 1'b0;
                if (quotient != hold_q || remainder != hold_r || div_by_zero != hold_z)
                    held_ok = 1'b0;
            end
        end while (!done && edges < 40);
        $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b after %0d edges",
                 a, b, quotient, remainder, div_by_zero, edges);
        check("done_seen", done === 1'b1, $sformatf("done=%b", done), "done=1");
        check("result", {quotient, remainder, div_by_zero} === {eq, er, ez},
              $sformatf("q=%0d r=%0d dbz=%b", quotient, remainder, div_by_zero),
              $sformatf("q=%0d r=%0d dbz=%b", eq, er, ez));
        check("latency", edges == exp_edges, $sformatf("%0d", edges), $sformatf("%0d", exp_edges));
        check("busy_profile", (b != '0) ? (busy_all && busy_seen) : !busy_seen,
              $sformatf("seen=%b all=%b", busy_seen, busy_all),
              (b != '0) ? "busy high until done" : "busy never high");
        check("busy_at_done", busy === 1'b0, $sformatf("%b", busy), "0");
        check("hold_before_done", held_ok, $sformatf("%b", held_ok), "1");
        hold_q = eq;
        hold_r = er;
        hold_z = ez;
    endtask

    initial begin
        logic [DW-1:0] mq;
        logic [VW-1:0] mr;
        logic          mz;
        bit            flag;
        int            edges;

        vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, z: 1'b0};
        vecs[1] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, z: 1'b0};
        vecs[2] = '{a: 8'd5,   b: 4'd9,  q: 8'd0,   r: 4'd5, z: 1'b0};
        vecs[3] = '{a: 8'd225, b: 4'd15, q: 8'd15,  r: 4'd0, z: 1'b0};
        vecs[4] = '{a: 8'd100, b: 4'd0,  q: 8'd255, r: 4'd0, z: 1'b1};

        // Reset held with a request pending: clock must be ignored.
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 4'd3;
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, quotient, remainder, div_by_zero} === '0,
              $sformatf("busy=%b done=%b q=%0d r=%0d dbz=%b", busy, done, quotient, remainder, div_by_zero),
              "all zero");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, each op followed by an idle cycle to see done drop.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
            @(negedge clk);
            check("done_one_cycle", done === 1'b0, $sformatf("%b", done), "0");
        end

        // Back-to-back: second request presented in the DONE cycle.
        run_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        run_op(8'd5,   4'd9, 8'd0,  4'd5, 1'b0);
        run_op(8'd100, 4'd0, 8'd255, 4'd0, 1'b1);
        run_op(8'd225, 4'd15, 8'd15, 4'd0, 1'b0);
        @(negedge clk);

        // Start pulsed during RUN is dropped, not queued.
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (!done && edges < 20);
        $display("op 200/7 with 50/3 during run -> q=%0d r=%0d dbz=%0b", quotient, remainder, div_by_zero);
        check("ignore_done", done === 1'b1, $sformatf("%b", done), "1");
        check("ignore_result", {quotient, remainder, div_by_zero} === {8'd28, 4'd4, 1'b0},
              $sformatf("q=%0d r=%0d", quotient, remainder), "q=28 r=4");
        flag = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) flag = 1'b1;
        end
        check("ignore_no_second_op", !flag, $sformatf("%b", flag), "0");
        hold_q = 8'd28;
        hold_r = 4'd4;
        hold_z = 1'b0;

        // Reset four cycles into a division aborts it.
        run_op(8'd100, 4'd0, 8'd255, 4'd0, 1'b1);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("reset mid-op -> busy=%0b done=%0b q=%0d r=%0d dbz=%0b",
                 busy, done, quotient, remainder, div_by_zero);
        check("abort_outputs", {busy, done, quotient, remainder, div_by_zero} === '0,
              $sformatf("busy=%b done=%b q=%0d r=%0d dbz=%b", busy, done, quotient, remainder, div_by_zero),
              "all zero");
        @(negedge clk);
        rst_n = 1'b1;
        flag  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) flag = 1'b1;
        end
        check("abort_no_done", !flag, $sformatf("%b", flag), "0");
        hold_q = '0;
        hold_r = '0;
        hold_z = 1'b0;
        run_op(8'd9, 4'd2, 8'd4, 4'd1, 1'b0);

        // Every dividend/divisor pair in shuffled order, back to back.
        for (int i = 0; i < 4096; i++) perm[i] = i;
        for (int i = 4095; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int k = 0; k < 4096; k++) begin
            logic [DW-1:0] a;
            logic [VW-1:0] b;
            a = DW'(perm[k] >> VW);
            b = VW'(perm[k]);
            ref_div(a, b, mq, mr, mz);
            run_op(a, b, mq, mr, mz);
            if (b != '0)
                check("invariant",
                      (int'(quotient) * int'(b) + int'(remainder) == int'(a)) && (remainder < b),
                      $sformatf("%0d*%0d+%0d", quotient, b, remainder), $sformatf("%0d, r<%0d", a, b));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
